// File: rtl/rob_pkg.sv
// Shared types and the operand-lookup helper for the reorder buffer.
package rob_pkg;

  localparam int unsigned RobSize = 16;
  localparam int unsigned RobIdW  = 4;

  typedef logic [RobIdW-1:0] rob_id_t;

  typedef enum logic [1:0] {
    TReg    = 2'd0,
    TStore  = 2'd1,
    TBranch = 2'd2,
    THalt   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        rdy;
    logic [31:0] val;
  } lookup_t;

  // Stored value wins over a same-cycle broadcast; lsb wins over rs.
  function automatic lookup_t rob_lookup(input logic        st_rdy,
                                         input logic [31:0] st_val,
                                         input rob_id_t     id,
                                         input logic        rs_vld,
                                         input rob_id_t     rs_id,
                                         input logic [31:0] rs_val,
                                         input logic        lsb_vld,
                                         input rob_id_t     lsb_id,
                                         input logic [31:0] lsb_val);
    lookup_t r;
    logic    rs_hit;
    logic    lsb_hit;
    rs_hit  = rs_vld && (rs_id == id);
    lsb_hit = lsb_vld && (lsb_id == id);
    r.rdy   = st_rdy | rs_hit | lsb_hit;
    if (st_rdy)       r.val = st_val;
    else if (lsb_hit) r.val = lsb_val;
    else if (rs_hit)  r.val = rs_val;
    else              r.val = st_val;
    return r;
  endfunction

endpackage

// File: rtl/rob_if.sv
// Issue, writeback, lookup and retirement signals of the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  logic        is_dc;
  rob_type_e   dc_type;
  logic [4:0]  dc_rd;
  logic [31:0] dc_pc;
  logic        dc_pred_taken;
  logic [31:0] dc_br_target;
  rob_id_t     rob_tail;
  logic        rob_full;

  rob_id_t     q1_id;
  rob_id_t     q2_id;
  logic        q1_rdy;
  logic        q2_rdy;
  logic [31:0] q1_val;
  logic [31:0] q2_val;

  logic        rs_has_output;
  rob_id_t     rs_rob_id;
  logic [31:0] rs_output;
  logic        is_lsb;
  rob_id_t     lsb_rob_id;
  logic [31:0] lsb_res;

  logic        commit_reg;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  rob_id_t     commit_id;
  logic        commit_store;
  logic        rob_clear;
  logic [31:0] clear_pc;
  logic        rob_halt;

  modport master (
    output is_dc, dc_type, dc_rd, dc_pc, dc_pred_taken, dc_br_target, q1_id, q2_id,
           rs_has_output, rs_rob_id, rs_output, is_lsb, lsb_rob_id, lsb_res,
    input  rob_tail, rob_full, q1_rdy, q2_rdy, q1_val, q2_val, commit_reg, commit_rd,
           commit_val, commit_id, commit_store, rob_clear, clear_pc, rob_halt
  );

  modport slave (
    input  is_dc, dc_type, dc_rd, dc_pc, dc_pred_taken, dc_br_target, q1_id, q2_id,
           rs_has_output, rs_rob_id, rs_output, is_lsb, lsb_rob_id, lsb_res,
    output rob_tail, rob_full, q1_rdy, q2_rdy, q1_val, q2_val, commit_reg, commit_rd,
           commit_val, commit_id, commit_store, rob_clear, clear_pc, rob_halt
  );

endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order result capture, one in-order
// retirement per cycle with register write, store release, mispredict flush and halt.
module rob
  import rob_pkg::*;
(
  input logic  clk_in,
  input logic  rst_in,
  input logic  rdy_in,
  rob_if.slave bus
);

  logic [RobSize-1:0] busy_q, ready_q, pred_q;
  rob_type_e          type_q   [RobSize];
  logic [4:0]         rd_q     [RobSize];
  logic [31:0]        pc_q     [RobSize];
  logic [31:0]        target_q [RobSize];
  logic [31:0]        val_q    [RobSize];

  rob_id_t     head_q, tail_q;
  logic [4:0]  count_q;
  logic        commit_reg_q, commit_store_q, rob_clear_q, rob_halt_q;
  logic [4:0]  commit_rd_q;
  logic [31:0] commit_val_q, clear_pc_q;
  rob_id_t     commit_id_q;

  logic    flush, do_issue, do_commit, wb_rs, wb_lsb, rs_hit_tail, lsb_hit_tail, mispred;
  lookup_t q1, q2;

  always_comb begin
    // The cycle rob_clear is high is the flush cycle: nothing else may happen in it.
    flush        = rob_clear_q;
    do_issue     = bus.is_dc && !flush;
    do_commit    = busy_q[head_q] && ready_q[head_q] && !rob_halt_q && !flush;
    wb_rs        = bus.rs_has_output && busy_q[bus.rs_rob_id];
    wb_lsb       = bus.is_lsb && busy_q[bus.lsb_rob_id];
    rs_hit_tail  = bus.rs_has_output && (bus.rs_rob_id == tail_q);
    lsb_hit_tail = bus.is_lsb && (bus.lsb_rob_id == tail_q);
    mispred      = val_q[head_q][0] != pred_q[head_q];
    q1 = rob_lookup(ready_q[bus.q1_id], val_q[bus.q1_id], bus.q1_id, bus.rs_has_output,
                    bus.rs_rob_id, bus.rs_output, bus.is_lsb, bus.lsb_rob_id, bus.lsb_res);
    q2 = rob_lookup(ready_q[bus.q2_id], val_q[bus.q2_id], bus.q2_id, bus.rs_has_output,
                    bus.rs_rob_id, bus.rs_output, bus.is_lsb, bus.lsb_rob_id, bus.lsb_res);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      pred_q         <= '0;
      for (int unsigned i = 0; i < RobSize; i++) begin
        type_q[i]   <= TReg;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
        val_q[i]    <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_reg_q   <= 1'b0;
      commit_store_q <= 1'b0;
      rob_clear_q    <= 1'b0;
      rob_halt_q     <= 1'b0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      clear_pc_q     <= '0;
      commit_id_q    <= '0;
    end else if (rdy_in) begin
      commit_reg_q   <= 1'b0;
      commit_store_q <= 1'b0;
      rob_clear_q    <= 1'b0;
      if (flush) begin
        busy_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (wb_rs) begin
          ready_q[bus.rs_rob_id] <= 1'b1;
          val_q[bus.rs_rob_id]   <= bus.rs_output;
        end
        if (wb_lsb) begin
          ready_q[bus.lsb_rob_id] <= 1'b1;
          val_q[bus.lsb_rob_id]   <= bus.lsb_res;
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + 1'b1;
          commit_id_q    <= head_q;
          unique case (type_q[head_q])
            TReg: begin
              commit_reg_q <= 1'b1;
              commit_rd_q  <= rd_q[head_q];
              commit_val_q <= val_q[head_q];
            end
            TStore:  commit_store_q <= 1'b1;
            TBranch: begin
              if (mispred) begin
                rob_clear_q <= 1'b1;
                clear_pc_q  <= val_q[head_q][0] ? target_q[head_q] : pc_q[head_q] + 32'd4;
              end
            end
            THalt:   rob_halt_q <= 1'b1;
          endcase
        end
        // Issue last so it overrides a retirement of the same slot when full.
        if (do_issue) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= (bus.dc_type == THalt) || rs_hit_tail || lsb_hit_tail;
          val_q[tail_q]    <= lsb_hit_tail ? bus.lsb_res : rs_hit_tail ? bus.rs_output : '0;
          type_q[tail_q]   <= bus.dc_type;
          rd_q[tail_q]     <= bus.dc_rd;
          pc_q[tail_q]     <= bus.dc_pc;
          pred_q[tail_q]   <= bus.dc_pred_taken;
          target_q[tail_q] <= bus.dc_br_target;
          tail_q           <= tail_q + 1'b1;
        end
        count_q <= count_q + 5'(do_issue) - 5'(do_commit);
      end
    end
  end

  assign bus.rob_tail     = tail_q;
  assign bus.rob_full     = count_q == 5'(RobSize);
  assign bus.q1_rdy       = q1.rdy;
  assign bus.q1_val       = q1.val;
  assign bus.q2_rdy       = q2.rdy;
  assign bus.q2_val       = q2.val;
  assign bus.commit_reg   = commit_reg_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_val   = commit_val_q;
  assign bus.commit_id    = commit_id_q;
  assign bus.commit_store = commit_store_q;
  assign bus.rob_clear    = rob_clear_q;
  assign bus.clear_pc     = clear_pc_q;
  assign bus.rob_halt     = rob_halt_q;

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: expected retirements are queued at issue and popped on each pulse.
module tb_rob;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rob_if bus ();

  rob u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // kind = {commit_reg, commit_store, rob_clear}; val doubles as clear_pc for flushes
  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  id;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [4:0] rd,
                          input logic [31:0] val, input logic [3:0] id);
    exp_t e;
    e.kind = kind;
    e.rd   = rd;
    e.val  = val;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    bus.is_dc         = 1'b0;
    bus.dc_type       = TReg;
    bus.dc_rd         = '0;
    bus.dc_pc         = '0;
    bus.dc_pred_taken = 1'b0;
    bus.dc_br_target  = '0;
    bus.q1_id         = '0;
    bus.q2_id         = '0;
    bus.rs_has_output = 1'b0;
    bus.rs_rob_id     = '0;
    bus.rs_output     = '0;
    bus.is_lsb        = 1'b0;
    bus.lsb_rob_id    = '0;
    bus.lsb_res       = '0;
  endtask

  task automatic tick();
    if (bus.is_dc) check_eq("issue_not_full", {31'd0, bus.rob_full}, 32'd0);
    @(posedge clk);
    #1;
    bus.is_dc         = 1'b0;
    bus.rs_has_output = 1'b0;
    bus.is_lsb        = 1'b0;
  endtask

  task automatic set_issue(input rob_type_e t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic pred, input logic [31:0] tgt);
    bus.is_dc         = 1'b1;
    bus.dc_type       = t;
    bus.dc_rd         = rd;
    bus.dc_pc         = pc;
    bus.dc_pred_taken = pred;
    bus.dc_br_target  = tgt;
  endtask

  task automatic bcast_rs(input logic [3:0] id, input logic [31:0] v);
    bus.rs_has_output = 1'b1;
    bus.rs_rob_id     = id;
    bus.rs_output     = v;
  endtask

  task automatic bcast_lsb(input logic [3:0] id, input logic [31:0] v);
    bus.is_lsb     = 1'b1;
    bus.lsb_rob_id = id;
    bus.lsb_res    = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    check_eq({"drain_", tag}, sb.size(), 32'd0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Retirement monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && (bus.commit_reg || bus.commit_store || bus.rob_clear)) begin
      if (sb.size() == 0) begin
        check_eq("spurious_pulse", {29'd0, bus.commit_reg, bus.commit_store, bus.rob_clear},
                 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("pulse_kind", {29'd0, bus.commit_reg, bus.commit_store, bus.rob_clear},
                 {29'd0, e.kind});
        if (e.kind == 3'b100) begin
          check_eq("commit_rd", {27'd0, bus.commit_rd}, {27'd0, e.rd});
          check_eq("commit_val", bus.commit_val, e.val);
          check_eq("commit_id", {28'd0, bus.commit_id}, {28'd0, e.id});
        end else if (e.kind == 3'b010) begin
          check_eq("store_id", {28'd0, bus.commit_id}, {28'd0, e.id});
        end else begin
          check_eq("clear_pc", bus.clear_pc, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    do_reset();
    check_eq("reset_tail", {28'd0, bus.rob_tail}, 32'd0);
    check_eq("reset_full", {31'd0, bus.rob_full}, 32'd0);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) begin
      set_issue(TReg, 5'(i + 1), 32'h0, 1'b0, 32'h0);
      tick();
    end
    check_eq("tail_before_rst", {28'd0, bus.rob_tail}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_tail", {28'd0, bus.rob_tail}, 32'd0);
    check_eq("rst_full", {31'd0, bus.rob_full}, 32'd0);
    check_eq("rst_outs", {27'd0, bus.commit_reg, bus.commit_store, bus.rob_clear,
                          bus.rob_halt, 1'b0}, 32'd0);
    check_eq("rst_clear_pc", bus.clear_pc, 32'd0);
    do_reset();

    // In-order retirement despite out-of-order results
    set_issue(TReg, 5'd5, 32'h0, 1'b0, 32'h0); push_exp(3'b100, 5'd5, 32'h11, 4'd0); tick();
    set_issue(TReg, 5'd6, 32'h4, 1'b0, 32'h0); push_exp(3'b100, 5'd6, 32'h33, 4'd1); tick();
    set_issue(TReg, 5'd7, 32'h8, 1'b0, 32'h0); push_exp(3'b100, 5'd7, 32'h22, 4'd2); tick();
    bcast_rs(4'd2, 32'h22); tick();
    bcast_rs(4'd0, 32'h11); tick();
    bcast_rs(4'd1, 32'h33); tick();
    wait_drain("inorder");

    // Full, wrap, and simultaneous issue + commit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(TReg, 5'(i + 1), 32'(i * 4), 1'b0, 32'h0);
      push_exp(3'b100, 5'(i + 1), 32'h1000 + 32'(i), 4'(i));
      tick();
    end
    check_eq("full_set", {31'd0, bus.rob_full}, 32'd1);
    check_eq("full_tail", {28'd0, bus.rob_tail}, 32'd0);
    bcast_rs(4'd0, 32'h1000);
    bcast_lsb(4'd1, 32'h1001);
    tick();
    tick();
    check_eq("after_commit_full", {31'd0, bus.rob_full}, 32'd0);
    check_eq("after_commit_tail", {28'd0, bus.rob_tail}, 32'd0);
    set_issue(TReg, 5'd20, 32'h40, 1'b0, 32'h0);
    push_exp(3'b100, 5'd20, 32'h2000, 4'd0);
    tick();
    check_eq("issue_commit_full", {31'd0, bus.rob_full}, 32'd0);
    check_eq("wrap_tail", {28'd0, bus.rob_tail}, 32'd1);
    set_issue(TReg, 5'd21, 32'h44, 1'b0, 32'h0);
    push_exp(3'b100, 5'd21, 32'h2001, 4'd1);
    tick();
    check_eq("refull", {31'd0, bus.rob_full}, 32'd1);
    check_eq("refull_tail", {28'd0, bus.rob_tail}, 32'd2);
    for (int i = 2; i < 16; i++) begin
      bcast_rs(4'(i), 32'h1000 + 32'(i));
      tick();
    end
    bcast_rs(4'd0, 32'h2000); tick();
    bcast_rs(4'd1, 32'h2001); tick();
    wait_drain("full");

    // Mispredict flushes the younger ready entry
    do_reset();
    set_issue(TBranch, 5'd0, 32'h100, 1'b0, 32'h180);
    push_exp(3'b001, 5'd0, 32'h180, 4'd0);
    tick();
    set_issue(TReg, 5'd9, 32'h104, 1'b0, 32'h0);
    tick();
    bcast_rs(4'd0, 32'h1);
    bcast_lsb(4'd1, 32'h55);
    tick();
    wait_drain("mispredict");
    check_eq("flush_tail", {28'd0, bus.rob_tail}, 32'd0);
    check_eq("flush_full", {31'd0, bus.rob_full}, 32'd0);
    check_eq("clear_dropped", {31'd0, bus.rob_clear}, 32'd0);

    // Correct prediction: no clear; same-cycle broadcast at issue makes entries ready
    set_issue(TBranch, 5'd0, 32'h200, 1'b1, 32'h280);
    bcast_rs(4'd0, 32'h1);
    tick();
    set_issue(TReg, 5'd3, 32'h204, 1'b0, 32'h0);
    bcast_rs(4'd1, 32'h77);
    push_exp(3'b100, 5'd3, 32'h77, 4'd1);
    tick();
    wait_drain("predict_ok");

    // Operand lookup forwarding and bus priority
    do_reset();
    set_issue(TReg, 5'd10, 32'h0, 1'b0, 32'h0); push_exp(3'b100, 5'd10, 32'h10, 4'd0); tick();
    set_issue(TReg, 5'd11, 32'h4, 1'b0, 32'h0); push_exp(3'b100, 5'd11, 32'h2, 4'd1); tick();
    set_issue(TReg, 5'd0, 32'h8, 1'b0, 32'h0); push_exp(3'b100, 5'd0, 32'h30, 4'd2); tick();
    set_issue(TReg, 5'd12, 32'hc, 1'b0, 32'h0); push_exp(3'b100, 5'd12, 32'hABCD, 4'd3);
    bcast_rs(4'd3, 32'hABCD);
    bus.q1_id = 4'd3;
    bus.q2_id = 4'd0;
    #1;
    check_eq("fwd_q1_rdy", {31'd0, bus.q1_rdy}, 32'd1);
    check_eq("fwd_q1_val", bus.q1_val, 32'hABCD);
    check_eq("fwd_q2_rdy", {31'd0, bus.q2_rdy}, 32'd0);
    tick();
    check_eq("stored_q1_rdy", {31'd0, bus.q1_rdy}, 32'd1);
    check_eq("stored_q1_val", bus.q1_val, 32'hABCD);
    bcast_rs(4'd1, 32'h1);
    bcast_lsb(4'd1, 32'h2);
    bus.q2_id = 4'd1;
    #1;
    check_eq("prio_q2_rdy", {31'd0, bus.q2_rdy}, 32'd1);
    check_eq("prio_q2_val", bus.q2_val, 32'h2);
    tick();
    bcast_rs(4'd0, 32'h10); tick();
    bcast_rs(4'd2, 32'h30); tick();
    wait_drain("forward");

    // Store release then halt blocks later ready entries
    do_reset();
    set_issue(TStore, 5'd0, 32'h300, 1'b0, 32'h0); push_exp(3'b010, 5'd0, 32'h0, 4'd0); tick();
    set_issue(THalt, 5'd0, 32'h304, 1'b0, 32'h0); tick();
    set_issue(TReg, 5'd4, 32'h308, 1'b0, 32'h0); tick();
    bcast_lsb(4'd0, 32'h0); tick();
    bcast_rs(4'd2, 32'h99); tick();
    wait_drain("store_halt");
    for (int i = 0; i < 4; i++) tick();
    check_eq("halt_set", {31'd0, bus.rob_halt}, 32'd1);
    check_eq("halt_tail", {28'd0, bus.rob_tail}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
